uart_tx_ex: RTL

Parametrised UART transmitter: next generation of the compact fixed-format transmitter in the SoC UART subsystem. Adds an internal transmit FIFO with a valid/ready write port, runtime character length (5–8 bits), five parity modes, 1 or 2 stop bits, configurable oversampling ratio and line inversion. It sits between the APB UART register block and the pad, clocked by the system clock and paced by the shared baud-rate enable generator.

---
 rtl/uart_pkg.sv | 50 +++++
 rtl/uart_tx_ex_if.sv | 14 +
 rtl/uart_tx_fifo.sv | 45 ++++
 rtl/uart_tx_ex.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART encodings: parity modes, character lengths, transmitter FSM states.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      PAR_NONE  = 3'd0,
      PAR_EVEN  = 3'd1,
      PAR_ODD   = 3'd2,
      PAR_MARK  = 3'd3,
      PAR_SPACE = 3'd4
   } parity_e;

   typedef enum logic [1:0] {
      CLEN_5 = 2'b00,
      CLEN_6 = 2'b01,
      CLEN_7 = 2'b10,
      CLEN_8 = 2'b11
   } char_len_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
`ifdef UART_TX_BREAK_EN
      ST_BREAK,
`endif
      ST_STOP
   } state_e;

   function automatic logic [7:0] char_mask(input logic [1:0] cl);
      return 8'hFF >> (2'd3 - cl);
   endfunction

   // Returns {enable, level}; reserved modes behave as no parity.
   function automatic logic [1:0] parity_of(input logic [2:0] mode,
                                            input logic [7:0] data,
                                            input logic [1:0] cl);
      logic p;
      p = ^(data & char_mask(cl));
      case (mode)
         PAR_EVEN:  return {1'b1, p};
         PAR_ODD:   return {1'b1, ~p};
         PAR_MARK:  return 2'b11;
         PAR_SPACE: return 2'b10;
         default:   return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_ex_if.sv
// Write port of the transmitter FIFO: data/valid in, ready/level back.
interface uart_tx_ex_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    tx_data_i;
   logic          tx_valid_i;
   logic          tx_ready_o;
   logic [LW-1:0] fifo_level_o;

   modport master (output tx_data_i, tx_valid_i, input tx_ready_o, fifo_level_o);
   modport slave  (input tx_data_i, tx_valid_i, output tx_ready_o, fifo_level_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy level; full/empty come straight from the pointers.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_LVL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty.
   assign level   = wptr_q - rptr_q;
   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_tx_ex.sv
// uart_tx_ex: FIFO-buffered UART transmitter, runtime frame format, paced by baud_tick_i.
// Define UART_TX_BREAK_EN to add the break_i port and the BREAK state.
module uart_tx_ex
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int OSR        = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        baud_tick_i,
   input  logic        msb_first_i,
   input  logic [1:0]  char_len_i,
   input  logic [2:0]  parity_mode_i,
   input  logic        stop2_i,
   input  logic        invert_i,
`ifdef UART_TX_BREAK_EN
   input  logic        break_i,
`endif
   uart_tx_ex_if.slave wr,
   output logic        serial_out_o,
   output logic        busy_o,
   output logic        tx_complete_o
);
   localparam logic [4:0] CNT_MAX = 5'(OSR - 1);

   state_e     state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic       line_q, line_d;
   logic       done_q, done_d;
   logic [7:0] char_q;
   logic [1:0] cl_q, par_q;
   logic       msb_q, stop2_q, inv_q;
   logic       last, load;
   logic       fifo_empty, fifo_full;
   logic [7:0] fifo_rdata;
`ifdef UART_TX_BREAK_EN
   logic       brk_load;
`endif

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr.tx_valid_i),
      .pop   (load),
      .wdata (wr.tx_data_i),
      .rdata (fifo_rdata),
      .level (wr.fifo_level_o),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign wr.tx_ready_o = ~fifo_full;

   // Data bit i of the latched character in wire order; top index is char_len+4.
   function automatic logic pick_bit(input logic [7:0] c, input logic [1:0] cl,
                                     input logic msb, input logic [2:0] i);
      logic [2:0] idx;
      idx = msb ? ({1'b1, cl} - i) : i;
      return c[idx];
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      line_d  = line_q;
      done_d  = 1'b0;
      load    = 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_load = 1'b0;
`endif
      last = baud_tick_i && (cnt_q == CNT_MAX);
      if (state_q != ST_IDLE && baud_tick_i)
         cnt_d = last ? 5'd0 : cnt_q + 5'd1;

      case (state_q)
         ST_IDLE: begin
            line_d = ~invert_i;
            if (baud_tick_i) begin
`ifdef UART_TX_BREAK_EN
               if (break_i) begin
                  state_d  = ST_BREAK;
                  brk_load = 1'b1;
                  line_d   = invert_i;
               end else
`endif
               if (!fifo_empty) load = 1'b1;
            end
         end
         ST_START: if (last) begin
            state_d = ST_DATA;
            bit_d   = 3'd0;
            line_d  = pick_bit(char_q, cl_q, msb_q, 3'd0) ^ inv_q;
         end
         ST_DATA: if (last) begin
            if (bit_q == {1'b1, cl_q}) begin
               bit_d = 3'd0;
               if (par_q[1]) begin
                  state_d = ST_PARITY;
                  line_d  = par_q[0] ^ inv_q;
               end else begin
                  state_d = ST_STOP;
                  line_d  = ~inv_q;
               end
            end else begin
               bit_d  = bit_q + 3'd1;
               line_d = pick_bit(char_q, cl_q, msb_q, bit_q + 3'd1) ^ inv_q;
            end
         end
         ST_PARITY: if (last) begin
            state_d = ST_STOP;
            line_d  = ~inv_q;
         end
         ST_STOP: if (last) begin
            if (bit_q == 3'd0 && stop2_q) begin
               bit_d = 3'd1;
            end else begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
               line_d  = ~invert_i;
`ifdef UART_TX_BREAK_EN
               if (break_i) begin
                  state_d = ST_BREAK;
                  line_d  = inv_q;
               end else
`endif
               if (!fifo_empty) load = 1'b1;
            end
         end
`ifdef UART_TX_BREAK_EN
         // Space while requested, then one full bit period of mark before idling.
         ST_BREAK: begin
            line_d = break_i ? inv_q : ~inv_q;
            if (break_i)   cnt_d   = 5'd0;
            else if (last) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Back-to-back frames: the pop and start bit share the final stop tick.
      if (load) begin
         state_d = ST_START;
         cnt_d   = 5'd0;
         bit_d   = 3'd0;
         line_d  = invert_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         line_q  <= 1'b1;
         done_q  <= 1'b0;
         char_q  <= '0;
         cl_q    <= '0;
         par_q   <= '0;
         msb_q   <= 1'b0;
         stop2_q <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         line_q  <= line_d;
         done_q  <= done_d;
         if (load) begin
            char_q  <= fifo_rdata & char_mask(char_len_i);
            cl_q    <= char_len_i;
            par_q   <= parity_of(parity_mode_i, fifo_rdata, char_len_i);
            msb_q   <= msb_first_i;
            stop2_q <= stop2_i;
            inv_q   <= invert_i;
         end
`ifdef UART_TX_BREAK_EN
         else if (brk_load) inv_q <= invert_i;
`endif
      end
   end

   assign serial_out_o  = line_q;
   assign tx_complete_o = done_q;
   assign busy_o        = (state_q != ST_IDLE);

endmodule
